// File: rtl/spi_ram_burst.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_ram_burst: command-decoding single-port RAM behind an SPI slave,     |
// | with independent write/read pointers. Optional macro:                    |
// | SPI_RAM_AUTO_INC_EN (pointers advance after each successful data cmd).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              cmd_err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              wr_set_q, wr_set_d;
  logic              rd_set_q, rd_set_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              cmd_err_q, cmd_err_d;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              addr_ok;
  logic              mem_we;

  assign cmd     = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  // Full payload is range-checked so a non-power-of-two depth rejects e.g. 200..255.
  assign addr_ok = (32'(payload) < 32'(MEM_DEPTH));

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_set_d   = wr_set_q;
    rd_set_d   = rd_set_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (addr_ok) begin
            wr_ptr_d = payload[ADDR_W-1:0];
            wr_set_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wr_set_q) begin
            mem_we = 1'b1;
            if (AUTO_INC) wr_ptr_d = next_ptr(wr_ptr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (addr_ok) begin
            rd_ptr_d = payload[ADDR_W-1:0];
            rd_set_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          if (rd_set_q) begin
            dout_d     = mem[rd_ptr_q];
            tx_valid_d = 1'b1;
            if (AUTO_INC) rd_ptr_d = next_ptr(rd_ptr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: cmd_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_set_q   <= 1'b0;
      rd_set_q   <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_set_q   <= wr_set_d;
      rd_set_q   <= rd_set_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= payload;
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule
`default_nettype wire
